// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential signed 3-digit BCD to N-bit two's-complement
// converter using reverse double dabble (shift right, then subtract 3 from
// every BCD nibble that is 8 or more).
//
// Optional feature macro: BCD2BIN_SATURATE_EN
//   defined   -> on overflow, binary clamps to the nearest representable value
//   undefined -> on overflow, binary is the low N bits of the exact value
// overflow itself asserts identically in both builds.

module bcd_to_binary #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sign,
    input  logic [3:0]   hundreds,
    input  logic [3:0]   tens,
    input  logic [3:0]   ones,
    output logic [N-1:0] binary,
    output logic         data_ready,
    output logic         busy,
    output logic         overflow,
    output logic         digit_error
);

    // Width wide enough to hold -999 and the N-bit range limits without truncation.
    localparam int W = ((N > 10) ? N : 10) + 1;

    localparam logic [W-1:0] POS_LIMIT = W'((64'd1 << (N - 1)) - 64'd1);
    localparam logic [W-1:0] NEG_LIMIT = W'(64'd1 << (N - 1));

    typedef enum logic [1:0] {
        IDLE,
        WORK,
        DONE
    } state_t;

    state_t      state;
    logic [21:0] shreg;      // {hundreds, tens, ones, acc[9:0]}
    logic [3:0]  count;
    logic        sign_q;
    logic        err_q;

    logic [21:0]  shifted;
    logic [21:0]  corrected;
    logic         err_in;
    logic [W-1:0] mag_ext;
    logic [W-1:0] value;
    logic         ovf_c;
    logic [N-1:0] res_c;

    // Input digit validity, evaluated on the sampling edge.
    always_comb begin
        err_in = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
    end

    // One reverse double dabble step: shift right, then correct each BCD nibble.
    always_comb begin
        shifted   = shreg >> 1;
        corrected = shifted;
        for (int unsigned i = 0; i < 3; i++) begin
            if (shifted[10 + 4*i +: 4] >= 4'd8) begin
                corrected[10 + 4*i +: 4] = shifted[10 + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Final result, range check and overflow handling from the accumulated magnitude.
    always_comb begin
        mag_ext = W'(shreg[9:0]);
        value   = sign_q ? ('0 - mag_ext) : mag_ext;
        if (err_q) begin
            ovf_c = 1'b0;
        end else if (!sign_q) begin
            ovf_c = (mag_ext > POS_LIMIT);
        end else begin
            ovf_c = (mag_ext > NEG_LIMIT);
        end

        if (err_q) begin
            res_c = '0;
        end else if (ovf_c) begin
`ifdef BCD2BIN_SATURATE_EN
            res_c = sign_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
            res_c = value[N-1:0];
`endif
        end else begin
            res_c = value[N-1:0];
        end
    end

    // Control FSM, shift register and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            binary      <= '0;
            overflow    <= 1'b0;
            digit_error <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        shreg  <= {hundreds, tens, ones, 10'd0};
                        sign_q <= sign;
                        err_q  <= err_in;
                        count  <= 4'd10;
                        state  <= WORK;
                    end
                end
                WORK: begin
                    if (count != 4'd0) begin
                        shreg <= corrected;
                        count <= count - 4'd1;
                    end else begin
                        binary      <= res_c;
                        overflow    <= ovf_c;
                        digit_error <= err_q;
                        state       <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags follow the state register directly.
    always_comb begin
        data_ready = (state == DONE);
        busy       = (state == WORK);
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed-vector scoreboard bench for bcd_to_binary,
// one instance at N=8 and one at N=16.

module tb_bcd_to_binary;

    typedef struct {
        logic [15:0] bin;
        logic        ovf;
        logic        err;
        int unsigned due;
    } exp_t;

`ifdef BCD2BIN_SATURATE_EN
    localparam logic [15:0] P128  = 16'h007F;
    localparam logic [15:0] N999  = 16'h0080;
    localparam logic [15:0] N129  = 16'h0080;
`else
    localparam logic [15:0] P128  = 16'h0080;
    localparam logic [15:0] N999  = 16'h0019;
    localparam logic [15:0] N129  = 16'h007F;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic        sign8 = 1'b0, sign16 = 1'b0;
    logic [3:0]  h8 = '0, t8 = '0, o8 = '0;
    logic [3:0]  h16 = '0, t16 = '0, o16 = '0;
    logic [7:0]  bin8;
    logic [15:0] bin16;
    logic        dr8, busy8, ovf8, err8;
    logic        dr16, busy16, ovf16, err16;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    exp_t        q8[$];
    exp_t        q16[$];
    logic        dr8_prev = 1'b0, dr16_prev = 1'b0;

    bcd_to_binary #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sign(sign8),
        .hundreds(h8), .tens(t8), .ones(o8),
        .binary(bin8), .data_ready(dr8), .busy(busy8),
        .overflow(ovf8), .digit_error(err8)
    );

    bcd_to_binary #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sign(sign16),
        .hundreds(h16), .tens(t16), .ones(o16),
        .binary(bin16), .data_ready(dr16), .busy(busy16),
        .overflow(ovf16), .digit_error(err16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor for the N=8 instance: compare on each new result.
    always @(negedge clk) begin
        if (!rst && dr8 && !dr8_prev) begin
            if (q8.size() == 0) begin
                check("n8_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("n8_binary",      {24'd0, bin8},  {16'd0, e.bin});
                check("n8_overflow",    {31'd0, ovf8},  {31'd0, e.ovf});
                check("n8_digit_error", {31'd0, err8},  {31'd0, e.err});
                check("n8_latency",     cyc,            e.due);
            end
        end
        dr8_prev = dr8;
    end

    // Scoreboard monitor for the N=16 instance.
    always @(negedge clk) begin
        if (!rst && dr16 && !dr16_prev) begin
            if (q16.size() == 0) begin
                check("n16_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q16.pop_front();
                check("n16_binary",      {16'd0, bin16}, {16'd0, e.bin});
                check("n16_overflow",    {31'd0, ovf16}, {31'd0, e.ovf});
                check("n16_digit_error", {31'd0, err16}, {31'd0, e.err});
                check("n16_latency",     cyc,            e.due);
            end
        end
        dr16_prev = dr16;
    end

    task automatic issue8(input logic s, input logic [3:0] h, input logic [3:0] t,
                          input logic [3:0] o, input logic [15:0] b,
                          input logic ov, input logic er);
        exp_t e;
        @(negedge clk);
        sign8 = s; h8 = h; t8 = t; o8 = o; start8 = 1'b1;
        e.bin = b; e.ovf = ov; e.err = er; e.due = cyc + 12;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        sign8 = ~s; h8 = 4'h9; t8 = 4'h9; o8 = 4'h9;
    endtask

    task automatic issue16(input logic s, input logic [3:0] h, input logic [3:0] t,
                           input logic [3:0] o, input logic [15:0] b);
        exp_t e;
        @(negedge clk);
        sign16 = s; h16 = h; t16 = t; o16 = o; start16 = 1'b1;
        e.bin = b; e.ovf = 1'b0; e.err = 1'b0; e.due = cyc + 12;
        q16.push_back(e);
        @(negedge clk);
        start16 = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_binary8",  {24'd0, bin8}, 32'd0);
        check("rst_flags8",   {28'd0, dr8, busy8, ovf8, err8}, 32'd0);
        check("rst_binary16", {16'd0, bin16}, 32'd0);
        check("rst_flags16",  {28'd0, dr16, busy16, ovf16, err16}, 32'd0);
        rst = 1'b0;

        // Basic conversion, then hold in DONE.
        issue8(1'b0, 4'd1, 4'd2, 4'd3, 16'h007B, 1'b0, 1'b0);
        check("busy_during_work", {31'd0, busy8}, 32'd1);
        repeat (12) @(negedge clk);
        repeat (5) @(negedge clk);
        check("hold_ready",  {31'd0, dr8}, 32'd1);
        check("hold_busy",   {31'd0, busy8}, 32'd0);
        check("hold_binary", {24'd0, bin8}, 32'h7B);

        // Negative boundary, then -0 restarted from DONE.
        issue8(1'b1, 4'd1, 4'd2, 4'd8, 16'h0080, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        issue8(1'b1, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0);
        check("restart_busy",   {31'd0, busy8}, 32'd1);
        check("restart_ready",  {31'd0, dr8},   32'd0);
        check("restart_holds",  {24'd0, bin8},  32'h80);
        repeat (12) @(negedge clk);

        // Range edges and overflow.
        issue8(1'b0, 4'd1, 4'd2, 4'd7, 16'h007F, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        issue8(1'b0, 4'd1, 4'd2, 4'd8, P128, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        issue8(1'b1, 4'd9, 4'd9, 4'd9, N999, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        issue8(1'b0, 4'd0, 4'd5, 4'd7, 16'h0039, 1'b0, 1'b0);
        repeat (12) @(negedge clk);

        // Invalid digit.
        issue8(1'b0, 4'd1, 4'hA, 4'd3, 16'h0000, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        issue8(1'b1, 4'd1, 4'd2, 4'd9, N129, 1'b1, 1'b0);
        repeat (12) @(negedge clk);

        // Start pulse during WORK must be ignored.
        issue8(1'b0, 4'd1, 4'd2, 4'd3, 16'h007B, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        sign8 = 1'b1; h8 = 4'd4; t8 = 4'd5; o8 = 4'd6; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Reset on the 5th WORK edge discards the conversion.
        issue8(1'b1, 4'd1, 4'd2, 4'd9, N129, 1'b1, 1'b0);
        void'(q8.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_binary", {24'd0, bin8}, 32'd0);
        check("midrst_flags",  {28'd0, dr8, busy8, ovf8, err8}, 32'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_stays_idle", {30'd0, dr8, busy8}, 32'd0);

        // Wide instance: no overflow possible.
        issue16(1'b0, 4'd9, 4'd9, 4'd9, 16'h03E7);
        repeat (12) @(negedge clk);
        issue16(1'b1, 4'd9, 4'd9, 4'd9, 16'hFC19);
        repeat (12) @(negedge clk);
        issue16(1'b1, 4'd1, 4'd2, 4'd8, 16'hFF80);
        repeat (12) @(negedge clk);

        repeat (3) @(negedge clk);
        check("n8_results_outstanding",  q8.size(),  32'd0);
        check("n16_results_outstanding", q16.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
